top_level: RTL and testbench

//  Self-contained arithmetic engine with an embedded 256x8 data memory; runs one fixed-point

---
 rtl/top_level_pkg.sv | 90 +++++++++
 rtl/data_mem.sv | 34 +++
 rtl/top_level.sv | 228 ++++++++++++++++++++++
 tb/tb_top_level.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/top_level_pkg.sv
// ----------------------------------------------------------------------------
// top_level_pkg
// Shared constants and types for the fixed-point arithmetic engine.
//   - Memory addresses of every program's operands and results.
//   - state_t : run sequencer states.
//   - prog_t  : which program the next launch executes.
//   - Helpers that map a program and byte index to memory addresses.
// Configuration macro: SQRT_EN (adds program P3, the rounded square root).
// ----------------------------------------------------------------------------
package top_level_pkg;

    localparam logic [7:0] P1_IN  = 8'd8;
    localparam logic [7:0] P1_OUT = 8'd10;
    localparam logic [7:0] P2_IN  = 8'd0;
    localparam logic [7:0] P2_DIV = 8'd2;
    localparam logic [7:0] P2_OUT = 8'd4;
    localparam logic [7:0] P3_IN  = 8'd13;
    localparam logic [7:0] P3_OUT = 8'd15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CALC  = 3'd2,
        ROUND = 3'd3,
        STORE = 3'd4,
        DONE  = 3'd5
    } state_t;

    // P1 is encoded as zero so a program selector that powers up cleared
    // starts the sequence at P1 without needing a reset.
    typedef enum logic [1:0] {
        PROG_P1 = 2'd0,
        PROG_P2 = 2'd1,
        PROG_P3 = 2'd2
    } prog_t;

    // Program that follows p in the launch sequence.
    function automatic prog_t progNext(input prog_t p);
        prog_t n;
        case (p)
            PROG_P1: n = PROG_P2;
`ifdef SQRT_EN
            PROG_P2: n = PROG_P3;
`else
            PROG_P2: n = PROG_P1;
`endif
            default: n = PROG_P1;
        endcase
        return n;
    endfunction

    // Index of the last operand byte read by program p.
    function automatic logic [1:0] lastLoadIdx(input prog_t p);
        return (p == PROG_P2) ? 2'd2 : 2'd1;
    endfunction

    // Index of the last result byte written by program p.
    function automatic logic [1:0] lastStoreIdx(input prog_t p);
        logic [1:0] n;
        case (p)
            PROG_P2: n = 2'd2;
            PROG_P3: n = 2'd0;
            default: n = 2'd1;
        endcase
        return n;
    endfunction

    // Operand address for byte idx; the P2 divisor has its own address.
    function automatic logic [7:0] loadAddr(input prog_t p, input logic [1:0] idx);
        logic [7:0] a;
        case (p)
            PROG_P2: a = (idx == 2'd2) ? P2_DIV : P2_IN + {6'd0, idx};
            PROG_P3: a = P3_IN + {6'd0, idx};
            default: a = P1_IN + {6'd0, idx};
        endcase
        return a;
    endfunction

    // Result address for byte idx, most significant byte first.
    function automatic logic [7:0] storeAddr(input prog_t p, input logic [1:0] idx);
        logic [7:0] a;
        case (p)
            PROG_P2: a = P2_OUT + {6'd0, idx};
            PROG_P3: a = P3_OUT + {6'd0, idx};
            default: a = P1_OUT + {6'd0, idx};
        endcase
        return a;
    endfunction

endpackage

// File: rtl/data_mem.sv
// ----------------------------------------------------------------------------
// data_mem
// 256 x 8 data memory, combinational read and registered write. The array is
// named core so that benches can preload and inspect it hierarchically.
// Ports:
//   i_clk   in  1  write clock
//   i_we    in  1  write enable
//   i_waddr in  8  write address
//   i_wdata in  8  write data
//   i_raddr in  8  read address
//   o_rdata out 8  read data (same cycle)
// ----------------------------------------------------------------------------
module data_mem (
    input  logic       i_clk,
    input  logic       i_we,
    input  logic [7:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [7:0] i_raddr,
    output logic [7:0] o_rdata
);

    logic [7:0] core [0:255];

    // Contents are never cleared; operands survive reset so they can be
    // loaded while the engine is held in reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            core[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = core[i_raddr];

endmodule

// File: rtl/top_level.sv
// ----------------------------------------------------------------------------
// top_level
// Fixed-point arithmetic engine with an embedded data memory. Each launch runs
// one program, in the order P1 (1/x), P2 (x/y), P3 (sqrt), then wraps.
// Operands are read from memory one byte per cycle, the result is computed
// bit-serially, rounded, and written back one byte per cycle.
// Ports:
//   CLK   in  1  clock
//   start in  1  synchronous active-high reset; a run begins once it falls
//   halt  out 1  high while a finished run is held, low in reset or running
// Configuration macro: SQRT_EN enables P3; without it the sequence is P1,P2.
// ----------------------------------------------------------------------------
module top_level
    import top_level_pkg::*;
(
    input  logic CLK,
    input  logic start,
    output logic halt
);

    state_t      r_state;
    state_t      w_nextState;
    prog_t       r_progSel;

    logic [1:0]  r_byteIdx;
    logic [4:0]  r_count;
    logic [15:0] r_loadBuf;
    logic [24:0] r_dividend;
    logic [15:0] r_divisor;
    logic [15:0] r_rem;
    logic [24:0] r_quot;
    logic        r_divZero;
    logic [23:0] r_result;

    logic [7:0]  w_raddr;
    logic [7:0]  w_rdata;
    logic        w_we;
    logic [7:0]  w_waddr;
    logic [7:0]  w_wdata;
    logic        w_loadLast;
    logic        w_storeLast;
    logic [23:0] w_buf;
    logic [16:0] w_trial;
    logic [15:0] w_diff;
    logic        w_fits;
    logic [23:0] w_round24;
    logic        w_isSqrt;
    logic [7:0]  w_rootNext;
    logic [7:0]  w_sqrtResult;

    data_mem data_mem1 (
        .i_clk   (CLK),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign w_loadLast  = (r_byteIdx == lastLoadIdx(r_progSel));
    assign w_storeLast = (r_byteIdx == lastStoreIdx(r_progSel));
    assign w_buf       = {r_loadBuf, w_rdata};

    // One restoring-division step: bring down the next dividend bit and
    // subtract the divisor when it fits. The remainder always stays below the
    // divisor, so 16 bits of difference are exact.
    assign w_trial = {r_rem, r_dividend[24]};
    assign w_fits  = (w_trial >= {1'b0, r_divisor});
    assign w_diff  = w_trial[15:0] - r_divisor;

    // (q + 1) >> 1 written as (q >> 1) + lsb, which never needs a carry bit.
    assign w_round24 = r_quot[24:1] + {23'd0, r_quot[0]};

`ifdef SQRT_EN
    logic [15:0] r_radicand;
    logic [7:0]  w_sqTrial;
    logic        w_sqFits;
    logic [16:0] w_ffPlus;

    // Bitwise square root: try setting each root bit from the top down and
    // keep it when the trial root squared does not exceed the radicand.
    assign w_isSqrt   = (r_progSel == PROG_P3);
    assign w_sqTrial  = r_quot[7:0] | (8'd1 << r_count[2:0]);
    assign w_sqFits   = (({8'd0, w_sqTrial} * {8'd0, w_sqTrial}) <= r_radicand);
    assign w_rootNext = w_sqFits ? w_sqTrial : r_quot[7:0];

    // Round to nearest: f*f + f is the midpoint between f^2 and (f+1)^2.
    // The root saturates at 255 so it still fits one byte.
    assign w_ffPlus     = {1'b0, {8'd0, r_quot[7:0]} * {8'd0, r_quot[7:0]}} + {9'd0, r_quot[7:0]};
    assign w_sqrtResult = ((r_quot[7:0] != 8'hFF) && ({1'b0, r_radicand} > w_ffPlus))
                          ? (r_quot[7:0] + 8'd1) : r_quot[7:0];

    // Radicand is captured as the last operand byte arrives.
    always_ff @(posedge CLK) begin
        if (start) begin
            r_radicand <= '0;
        end else if ((r_state == LOAD) && w_loadLast && w_isSqrt) begin
            r_radicand <= w_buf[15:0];
        end
    end
`else
    assign w_isSqrt     = 1'b0;
    assign w_rootNext   = 8'd0;
    assign w_sqrtResult = 8'd0;
`endif

    // State register; start doubles as a synchronous reset and aborts any run.
    always_ff @(posedge CLK) begin
        if (start) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and memory-port control. Writes are suppressed while start
    // is high so reset never disturbs memory.
    always_comb begin
        w_nextState = r_state;
        w_raddr     = loadAddr(r_progSel, r_byteIdx);
        w_we        = 1'b0;
        w_waddr     = storeAddr(r_progSel, r_byteIdx);
        w_wdata     = r_result[7:0];
        case (r_state)
            IDLE:  w_nextState = LOAD;
            LOAD:  if (w_loadLast) w_nextState = CALC;
            CALC:  if (r_count == 5'd0) w_nextState = ROUND;
            ROUND: w_nextState = STORE;
            STORE: begin
                w_we = !start;
                if (w_storeLast) w_nextState = DONE;
            end
            DONE:  w_nextState = DONE;
            default: w_nextState = IDLE;
        endcase
        // Bytes go out most significant first.
        case (lastStoreIdx(r_progSel) - r_byteIdx)
            2'd1:    w_wdata = r_result[15:8];
            2'd2:    w_wdata = r_result[23:16];
            default: w_wdata = r_result[7:0];
        endcase
    end

    // Program selector is deliberately left out of reset so the sequence
    // continues across launches; it advances when the last byte commits.
    always_ff @(posedge CLK) begin
        if (!start && (r_state == STORE) && w_storeLast) begin
            r_progSel <= progNext(r_progSel);
        end
    end

    // Datapath: gather operands, iterate, round, then step through the stores.
    // Dividends are left-aligned in a 25-bit shift register so both divisions
    // share one loop: P1 shifts in 2^16 over 17 steps, P2 shifts in N*2^9
    // over 25 steps.
    always_ff @(posedge CLK) begin
        if (start) begin
            r_byteIdx  <= '0;
            r_count    <= '0;
            r_loadBuf  <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_divZero  <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_byteIdx <= '0;
                    r_loadBuf <= '0;
                end
                LOAD: begin
                    r_loadBuf <= w_buf[15:0];
                    r_byteIdx <= r_byteIdx + 2'd1;
                    if (w_loadLast) begin
                        r_byteIdx <= '0;
                        r_rem     <= '0;
                        r_quot    <= '0;
                        case (r_progSel)
                            PROG_P2: begin
                                r_dividend <= {w_buf[23:8], 9'd0};
                                r_divisor  <= {8'd0, w_buf[7:0]};
                                r_divZero  <= (w_buf[7:0] == 8'd0);
                                r_count    <= 5'd24;
                            end
                            PROG_P3: begin
                                r_count <= 5'd7;
                            end
                            default: begin
                                r_dividend <= 25'h1000000;
                                r_divisor  <= w_buf[15:0];
                                r_divZero  <= (w_buf[15:0] == 16'd0);
                                r_count    <= 5'd16;
                            end
                        endcase
                    end
                end
                CALC: begin
                    r_count <= r_count - 5'd1;
                    if (w_isSqrt) begin
                        r_quot <= {17'd0, w_rootNext};
                    end else begin
                        r_dividend <= {r_dividend[23:0], 1'b0};
                        r_rem      <= w_fits ? w_diff : w_trial[15:0];
                        r_quot     <= {r_quot[23:0], w_fits};
                    end
                end
                ROUND: begin
                    r_byteIdx <= '0;
                    case (r_progSel)
                        PROG_P2: r_result <= r_divZero ? 24'hFFFFFF : w_round24;
                        PROG_P3: r_result <= {16'd0, w_sqrtResult};
                        default: r_result <= r_divZero ? 24'h00FFFF : {8'd0, w_round24[15:0]};
                    endcase
                end
                STORE: begin
                    r_byteIdx <= r_byteIdx + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign halt = (r_state == DONE);

endmodule

// File: tb/tb_top_level.sv
// ----------------------------------------------------------------------------
// tb_top_level
// Scoreboard bench for top_level. Each launch preloads operands into
// data_mem1.core, pushes the expected result bytes, and releases start; a
// monitor pops an entry whenever halt rises and compares memory contents and
// run latency. Directed operands come first, then random ones.
// ----------------------------------------------------------------------------
module tb_top_level;

    logic CLK = 1'b0;
    logic start = 1'b1;
    logic halt;

    top_level dut (
        .CLK   (CLK),
        .start (start),
        .halt  (halt)
    );

    always #5 CLK = ~CLK;

    // Posedge counter used to measure run latency.
    int cycle = 0;
    always @(posedge CLK) cycle++;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0]  base;
        logic [1:0]  nBytes;
        logic [23:0] value;
        logic [31:0] fallCycle;
    } exp_t;

    exp_t expQ[$];

    // Which program the next launch runs: 1, 2 or 3.
    int progNow = 1;
    int p1Idx = 0;
    int p2Idx = 0;
    int p3Idx = 0;
    logic [15:0] p1Dir [3] = '{16'h0003, 16'h0000, 16'h0001};
    logic [15:0] p2DirN [3] = '{16'h0001, 16'h0001, 16'hFFFF};
    logic [7:0]  p2DirD [3] = '{8'h03, 8'h00, 8'h01};
    logic [15:0] p3Dir [4] = '{16'd0, 16'd2, 16'd3, 16'd65535};

    // Reference model: results straight from the arithmetic definitions.
    function automatic logic [23:0] modelP1(input logic [15:0] d);
        longint q;
        if (d == 16'd0) return 24'h00FFFF;
        q = ((longint'(65536) / longint'(d)) + 1) / 2;
        return 24'(q % 65536);
    endfunction

    function automatic logic [23:0] modelP2(input logic [15:0] n, input logic [7:0] d);
        longint q;
        if (d == 8'd0) return 24'hFFFFFF;
        q = ((longint'(n) * 512 / longint'(d)) + 1) / 2;
        return 24'(q);
    endfunction

    function automatic logic [23:0] modelP3(input logic [15:0] x);
        int f;
        f = 0;
        while ((f + 1) * (f + 1) <= int'(x)) f++;
        if (f < 255 && int'(x) > f * f + f) f++;
        return 24'(f);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // One launch: preload operands in reset, optionally abort a first
    // attempt, then run to completion and confirm halt behaviour.
    task automatic applyStimulus(input bit abortFirst);
        logic [15:0] opA;
        logic [7:0]  opB;
        exp_t        e;
        bit          seen;

        @(negedge CLK);
        e.fallCycle = '0;
        case (progNow)
            1: begin
                opA = (p1Idx < 3) ? p1Dir[p1Idx]
                    : (($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom));
                p1Idx++;
                dut.data_mem1.core[8] = opA[15:8];
                dut.data_mem1.core[9] = opA[7:0];
                e.base = 8'd10; e.nBytes = 2'd2; e.value = modelP1(opA);
            end
            2: begin
                opA = (p2Idx < 3) ? p2DirN[p2Idx] : 16'($urandom);
                opB = (p2Idx < 3) ? p2DirD[p2Idx]
                    : (($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom));
                p2Idx++;
                dut.data_mem1.core[0] = opA[15:8];
                dut.data_mem1.core[1] = opA[7:0];
                dut.data_mem1.core[2] = opB;
                e.base = 8'd4; e.nBytes = 2'd3; e.value = modelP2(opA, opB);
            end
            default: begin
                opA = (p3Idx < 4) ? p3Dir[p3Idx] : 16'($urandom);
                p3Idx++;
                dut.data_mem1.core[13] = opA[15:8];
                dut.data_mem1.core[14] = opA[7:0];
                e.base = 8'd15; e.nBytes = 2'd1; e.value = modelP3(opA);
            end
        endcase

        if (abortFirst) begin
            start = 1'b0;
            repeat ($urandom_range(2, 8)) @(negedge CLK);
            start = 1'b1;
            @(negedge CLK);
            checkOutput("haltAfterAbort", {31'd0, halt}, 32'd0);
            @(negedge CLK);
            checkOutput("haltHeldInReset", {31'd0, halt}, 32'd0);
        end

        @(negedge CLK);
        e.fallCycle = 32'(cycle);
        expQ.push_back(e);
        start = 1'b0;

        seen = 1'b0;
        for (int w = 0; w < 60; w++) begin
            @(negedge CLK);
            if (expQ.size() == 0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL haltTimeout: halt=%0b after 60 cycles, required 1 within 40", halt);
            expQ.delete();
        end else begin
            repeat (2) @(negedge CLK);
            checkOutput("haltHeldDone", {31'd0, halt}, 32'd1);
        end

        start = 1'b1;
        @(negedge CLK);
        checkOutput("haltDropsOnStart", {31'd0, halt}, 32'd0);

        case (progNow)
            1: progNow = 2;
`ifdef SQRT_EN
            2: progNow = 3;
`else
            2: progNow = 1;
`endif
            default: progNow = 1;
        endcase
    endtask

    // Monitor: each rising edge of halt retires one scoreboard entry.
    initial begin : monitor
        logic prevHalt;
        exp_t e;
        int   lat;
        int   nb;
        prevHalt = 1'b0;
        forever begin
            @(negedge CLK);
            if (halt === 1'b1 && prevHalt !== 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedHalt: got halt=1 with no run pending, required 0");
                end else begin
                    e = expQ.pop_front();
                    lat = cycle - int'(e.fallCycle);
                    checks++;
                    if (lat > 40 || lat < 1) begin
                        failures++;
                        $display("[TB] FAIL latency: got %0d cycles, required 1..40", lat);
                    end
                    nb = int'(e.nBytes);
                    for (int i = 0; i < nb; i++) begin
                        checkOutput($sformatf("core[%0d]", int'(e.base) + i),
                                    {24'd0, dut.data_mem1.core[e.base + 8'(i)]},
                                    {24'd0, 8'(e.value >> (8 * (nb - 1 - i)))});
                    end
`ifndef SQRT_EN
                    checkOutput("core15Untouched", {24'd0, dut.data_mem1.core[15]}, 32'h000000A5);
`endif
                end
            end
            prevHalt = halt;
        end
    end

    initial begin : stimulus
        $display("[TB] start");
        dut.data_mem1.core[15] = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checkOutput("haltInReset", {31'd0, halt}, 32'd0);
        end
        for (int run = 0; run < 24; run++) begin
            applyStimulus(run % 5 == 3);
        end
        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
